// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side 2-bit branch history table.
// Counter encodings, table indexing and the saturating update rule.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_ctr_e;

    // State carried from F into D alongside the index
    typedef struct packed {
        logic     valid;
        logic     pred_taken;
        bht_ctr_e ctr;
    } fd_state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] bht_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic bht_ctr_e sat2_inc(input bht_ctr_e ctr, input logic taken);
        case (ctr)
            BHT_SNT: return taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: return taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  return taken ? BHT_ST  : BHT_WNT;
            default: return taken ? BHT_ST  : BHT_WT;
        endcase
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// F/D-side signals of the branch predictor. The pipeline drives through the
// master modport and the predictor sits on the slave modport.
interface branch_predictor_if;
    logic [31:0] F_PC;
    logic        F_VALID;
    logic        D_STALL;
    logic        D_FLUSH;
    logic        D_IS_BRANCH;
    logic        RES_CMP;
    logic        D_PRED_TAKEN;
    logic        MISPRED;
    logic [31:0] BR_CNT;
    logic [31:0] MISS_CNT;

    modport master (
        output F_PC, F_VALID, D_STALL, D_FLUSH, D_IS_BRANCH, RES_CMP,
        input  D_PRED_TAKEN, MISPRED, BR_CNT, MISS_CNT
    );

    modport slave (
        input  F_PC, F_VALID, D_STALL, D_FLUSH, D_IS_BRANCH, RES_CMP,
        output D_PRED_TAKEN, MISPRED, BR_CNT, MISS_CNT
    );
endinterface

// File: rtl/branch_predictor_bht_ram.sv
// 2^IDX_W x 2-bit counter file: one async read port with write-first bypass,
// one sync write port, synchronous reset of every entry to CTR_INIT.
module branch_predictor_bht_ram
    import branch_predictor_pkg::*;
#(
    parameter int       IDX_W    = 6,
    parameter bht_ctr_e CTR_INIT = BHT_WNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_e         rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bht_ctr_e         wr_data
);
    localparam int DEPTH = 1 << IDX_W;

    bht_ctr_e ctr_vec [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            bht_ctr_e ctr_q;
            bht_ctr_e ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ctr_d = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ctr_q <= CTR_INIT;
                end else begin
                    ctr_q <= ctr_d;
                end
            end

            assign ctr_vec[gi] = ctr_q;
        end
    endgenerate

    // A lookup of the entry being trained this cycle sees the trained value
    assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : ctr_vec[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit BHT: predicts at F, carries the prediction into D, trains on
// the D-stage comparator outcome and flags mispredicts to PC-select.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int       IDX_W    = 6,
    parameter bht_ctr_e CTR_INIT = BHT_WNT
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    logic [IDX_W-1:0] f_idx;
    bht_ctr_e         f_ctr;
    bht_ctr_e         train_ctr;
    logic             resolve;
    logic             mispred;

    fd_state_t        fd_q, fd_d;
    logic [IDX_W-1:0] d_idx_q, d_idx_d;
    logic [31:0]      br_cnt_q, br_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;

    assign f_idx = IDX_W'(bht_idx(bp.F_PC, IDX_W));

    branch_predictor_bht_ram #(
        .IDX_W    (IDX_W),
        .CTR_INIT (CTR_INIT)
    ) u_bht_ram (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (f_idx),
        .rd_data (f_ctr),
        .wr_en   (resolve),
        .wr_idx  (d_idx_q),
        .wr_data (train_ctr)
    );

    // The counter value captured at F stays exact while in D: only the D
    // branch trains the table, and the F read is bypassed on the training edge.
    always_comb begin
        resolve   = fd_q.valid & bp.D_IS_BRANCH & ~bp.D_STALL;
        mispred   = resolve & (bp.RES_CMP != fd_q.pred_taken);
        train_ctr = sat2_inc(fd_q.ctr, bp.RES_CMP);

        fd_d    = fd_q;
        d_idx_d = d_idx_q;
        if (!bp.D_STALL) begin
            fd_d.valid      = bp.F_VALID & ~bp.D_FLUSH;
            fd_d.pred_taken = f_ctr[1];
            fd_d.ctr        = f_ctr;
            d_idx_d         = f_idx;
        end

        br_cnt_d = br_cnt_q;
        if (resolve && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end

        miss_cnt_d = miss_cnt_q;
        if (mispred && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_q       <= '{valid: 1'b0, pred_taken: 1'b0, ctr: CTR_INIT};
            d_idx_q    <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            fd_q       <= fd_d;
            d_idx_q    <= d_idx_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp.D_PRED_TAKEN = fd_q.pred_taken;
    assign bp.MISPRED      = mispred;
    assign bp.BR_CNT       = br_cnt_q;
    assign bp.MISS_CNT     = miss_cnt_q;

endmodule
